mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width.
REQ-002 Parameter DATA_W, default 16, word width, fixed to two bytes.
REQ-003 Parameter MEM_BYTES, default 65536, byte-array depth (2**ADDR_W).
REQ-004 Parameter LATENCY, default 4, cycles from request accept to response valid; legal range 1..15.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  cache presents a request.
REQ-008 req_ready  output  1  responder can accept a request.
REQ-009 req_write  input  1  1 = word write, 0 = word read.
REQ-010 req_addr  input  ADDR_W  byte address of the low byte.
REQ-011 req_wdata  input  DATA_W  write data; [7:0] to addr, [15:8] to addr+1.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  cache consumes the response.
REQ-014 resp_rdata  output  DATA_W  read data {mem[addr+1], mem[addr]}; 0 for write responses.

Function
REQ-015 Request handshake SHALL complete on a cycle where req_valid and req_ready are both 1; addr, write and wdata SHALL be captured that cycle.
REQ-016 FSM states SHALL be IDLE, BUSY, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE -> BUSY on accept; the latency counter SHALL load LATENCY-1.
REQ-018 BUSY SHALL decrement the counter each cycle; at count 0 -> RESP on the next edge, giving resp_valid exactly LATENCY cycles after the accept edge.
REQ-019 A write SHALL commit both bytes to the array on the BUSY -> RESP edge, never earlier.
REQ-020 A read SHALL sample the array on the BUSY -> RESP edge and hold resp_rdata stable while in RESP.
REQ-021 RESP SHALL hold resp_valid = 1 until resp_valid and resp_ready are both 1, then -> IDLE.
REQ-022 No back-to-back overlap: a request presented in BUSY or RESP SHALL be stalled (req_ready = 0), not dropped or queued.
REQ-023 High-byte address SHALL be (addr + 1) mod 2**ADDR_W; addr 0xFFFF wraps the high byte to 0x0000.
REQ-024 Odd (unaligned) addresses SHALL be legal and access bytes addr and addr+1 exactly as written.
REQ-025 A read issued after a committed write to an overlapping byte SHALL return the new byte value.
REQ-026 resp_rdata SHALL be 0 outside RESP and for write responses.

Reset
REQ-027 While rst_n = 0: state IDLE, counter 0, req_ready 1 after release, resp_valid 0, resp_rdata 0.
REQ-028 Reset in BUSY SHALL abort the transaction; a pending write SHALL NOT be committed.
REQ-029 Array contents SHALL NOT be reset; reads of never-written bytes return X in simulation.

Structure
REQ-030 Shared package mem_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W defaults and the byte type.
REQ-031 No sub-module: counter, FSM and byte array live in mem_responder.

Verification
REQ-032 Write 0xBEEF @0x0010, LATENCY 4 -> resp_valid 4 cycles after accept; later read @0x0010 returns 0xBEEF; read @0x0011 returns {mem[0x12], 0xBE}.
REQ-033 Write 0x1234 @0xFFFF -> mem[0xFFFF] = 0x34, mem[0x0000] = 0x12; read @0xFFFF returns 0x1234.
REQ-034 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready 0, second req_valid stalled and accepted only after response handshake.
REQ-035 Write 0xAAAA @0x0020, assert rst_n = 0 at cycle 2 of BUSY -> resp_valid 0, FSM IDLE, prior contents of 0x0020/0x0021 unchanged.
REQ-036 LATENCY = 1 sweep: 16 random read/write pairs -> each response exactly 1 cycle after accept, data matches a byte-array reference model.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the word-wide memory responder:
// FSM state encoding, default widths and the byte storage type.
package mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_responder.sv
// Fixed-latency, single-outstanding word responder over a byte-addressed array.
// Writes commit and reads sample on the edge that enters RESP.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_BYTES = 2 ** ADDR_W,
    parameter int LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata
);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   addr_hi_s;
    logic                commit_s;
    byte_t               mem_q [MEM_BYTES];

    // High byte wraps naturally in ADDR_W bits.
    assign addr_hi_s  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign commit_s   = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;

    // Next-state, latency counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                    addr_d  = req_addr;
                    write_d = req_write;
                    wdata_d = req_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control and response registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            if (commit_s) begin
                rdata_q <= write_q ? '0 : {mem_q[addr_hi_s], mem_q[addr_q]};
            end else if ((state_q == ST_RESP) && resp_ready) begin
                rdata_q <= '0;
            end
        end
    end

    // Byte array: never reset; commit only happens with state_q in BUSY.
    always_ff @(posedge clk) begin
        if (commit_s && write_q) begin
            mem_q[addr_q]    <= wdata_q[7:0];
            mem_q[addr_hi_s] <= wdata_q[15:8];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a scoreboard queue and byte-array model;
// one instance at LATENCY 4 and one at LATENCY 1, selected by sel.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid, req_write, resp_ready;
    logic [15:0] req_addr, req_wdata;

    logic        ready_a, valid_a, ready_b, valid_b;
    logic [15:0] rdata_a, rdata_b;
    logic        ready_s, valid_s;
    logic [15:0] rdata_s;

    logic [7:0]  model [65536];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(valid_a), .resp_ready(resp_ready), .resp_rdata(rdata_a)
    );

    mem_responder #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(valid_b), .resp_ready(resp_ready), .resp_rdata(rdata_b)
    );

    assign ready_s = sel ? ready_b : ready_a;
    assign valid_s = sel ? valid_b : valid_a;
    assign rdata_s = sel ? rdata_b : rdata_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, record the expected response.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        int          n;
        logic [15:0] e;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (!ready_s && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_wait", {31'd0, ready_s}, 32'd1);
        if (w) begin
            e = 16'h0000;
            model[a] = d[7:0];
            model[a + 16'd1] = d[15:8];
        end else begin
            e = {model[a + 16'd1], model[a]};
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Count cycles from the accept edge to resp_valid, then compare and handshake.
    task automatic finish_resp(input int lat, input string tag);
        int          n;
        logic [15:0] e;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!valid_s && n < 40);
        chk({tag, "_latency"}, n, lat);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 16'hDEAD;
        chk({tag, "_rdata"}, {16'd0, rdata_s}, {16'd0, e});
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, {31'd0, valid_s}, 32'd0);
        chk({tag, "_rdata_zero"}, {16'd0, rdata_s}, 32'd0);
    endtask

    initial begin
        logic [15:0] a, d;
        logic [15:0] e;
        logic [7:0]  m0, m1;
        int          n;

        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000; resp_ready = 1'b1;
        #12;
        chk("rst_resp_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_resp_rdata", {16'd0, rdata_a}, 32'd0);
        chk("rst_req_ready", {31'd0, ready_a}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, ready_a}, 32'd1);

        issue(1'b1, 16'h0010, 16'hBEEF); finish_resp(4, "wr_0010");
        issue(1'b1, 16'h0012, 16'hC0DE); finish_resp(4, "wr_0012");
        issue(1'b0, 16'h0010, 16'h0000); finish_resp(4, "rd_0010");
        issue(1'b0, 16'h0011, 16'h0000); finish_resp(4, "rd_0011_odd");

        issue(1'b1, 16'hFFFF, 16'h1234); finish_resp(4, "wr_ffff");
        issue(1'b0, 16'hFFFF, 16'h0000); finish_resp(4, "rd_ffff_wrap");
        issue(1'b0, 16'h0000, 16'h0000); finish_resp(4, "rd_0000_wrapped");

        // Back-pressure: response held, second request stalled until handshake.
        resp_ready = 1'b0;
        issue(1'b0, 16'h0010, 16'h0000);
        req_write = 1'b0; req_addr = 16'hFFFF; req_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!valid_s && n < 40);
        chk("stall_latency", n, 4);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, valid_s}, 32'd1);
            chk("stall_rdata", {16'd0, rdata_s}, {16'd0, e});
            chk("stall_req_ready", {31'd0, ready_s}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_hs_valid", {31'd0, valid_s}, 32'd0);
        chk("stall_hs_ready", {31'd0, ready_s}, 32'd1);
        issue(1'b0, 16'hFFFF, 16'h0000); finish_resp(4, "stalled_rd_ffff");

        // Reset during BUSY aborts the pending write.
        issue(1'b1, 16'h0020, 16'h5566); finish_resp(4, "wr_0020");
        m0 = model[16'h0020]; m1 = model[16'h0021];
        issue(1'b1, 16'h0020, 16'hAAAA);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, valid_a}, 32'd0);
        chk("abort_idle_ready", {31'd0, ready_a}, 32'd1);
        chk("abort_rdata", {16'd0, rdata_a}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        model[16'h0020] = m0; model[16'h0021] = m1;
        exp_q.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("abort_still_idle", {31'd0, valid_a}, 32'd0);
        issue(1'b0, 16'h0020, 16'h0000); finish_resp(4, "rd_0020_after_abort");

        // LATENCY 1 sweep against the byte model.
        sel = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom);
            d = 16'($urandom);
            issue(1'b1, a, d); finish_resp(1, "sweep_wr");
            issue(1'b0, a, 16'h0000); finish_resp(1, "sweep_rd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
